// File: rtl/somador_serial_if.sv
// Handshake bundle for the bit-serial adder/subtractor.
// Operands in (in_valid/in_ready), result out (out_valid/out_ready).
interface somador_serial_if #(
  parameter int N = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         sub;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [N:0]   S;
  logic         ovf;

  modport master (
    output in_valid, A, B, sub, cin, out_ready,
    input  in_ready, out_valid, S, ovf
  );

  modport slave (
    input  in_valid, A, B, sub, cin, out_ready,
    output in_ready, out_valid, S, ovf
  );
endinterface

// File: rtl/somador_serial.sv
// Bit-serial adder/subtractor: one full-adder cell over N cycles.
// Ports: clk, rst_n (sync, active low), bus (somador_serial_if.slave).
module somador_serial #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst_n,
  somador_serial_if.slave bus
);
  localparam int CNT_W = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_n;

  logic [N-1:0]     ra, rb, sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [N:0]       s_q;
  logic             ovf_q;
  logic             sum, cnew, last;

  assign sum  = ra[0] ^ rb[0] ^ carry;
  assign cnew = (ra[0] & rb[0]) | (ra[0] & carry) | (rb[0] & carry);
  assign last = (cnt == CNT_W'(N - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n       = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_n = CALC;
      end
      CALC: begin
        if (last) state_n = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Sum bits collect in sh; S only updates on completion so the
  // previous result stays visible while a new one is computed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ra    <= '0;
      rb    <= '0;
      sh    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            ra    <= bus.A;
            rb    <= bus.sub ? ~bus.B : bus.B;
            carry <= bus.sub ? 1'b1 : bus.cin;
            cnt   <= '0;
          end
        end
        CALC: begin
          sh    <= {sum, sh[N-1:1]};
          ra    <= ra >> 1;
          rb    <= rb >> 1;
          carry <= cnew;
          cnt   <= cnt + CNT_W'(1);
          if (last) begin
            s_q   <= {cnew, sum, sh[N-1:1]};
            // carry into MSB vs carry out of MSB
            ovf_q <= carry ^ cnew;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.S   = s_q;
  assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_somador_serial.sv
// Directed self-checking bench for somador_serial (N=4).
// Drives and samples on the falling edge.
module tb_somador_serial;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  somador_serial_if #(.N(N)) bus ();

  somador_serial #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic sb, input logic ci);
    bus.A        = a;
    bus.B        = b;
    bus.sub      = sb;
    bus.cin      = ci;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Issue one operation and wait for out_valid; checks latency and result.
  task automatic do_op(input string tag, input logic [N-1:0] a,
                       input logic [N-1:0] b, input logic sb,
                       input logic ci, input logic [N:0] es,
                       input logic eo);
    int lat;
    lat = 99;
    issue(a, b, sb, ci);
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
    chk({tag, "_lat"}, lat, N);
    chk({tag, "_S"}, 32'(bus.S), 32'(es));
    chk({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
  endtask

  task automatic pop(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_pop_ov"}, 32'(bus.out_valid), 0);
    chk({tag, "_pop_ir"}, 32'(bus.in_ready), 1);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.sub       = 1'b0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ir", 32'(bus.in_ready), 1);
    chk("rst_ov", 32'(bus.out_valid), 0);
    chk("rst_S", 32'(bus.S), 0);
    chk("rst_ovf", 32'(bus.ovf), 0);

    // out_ready with nothing pending does nothing
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("idle_or_ov", 32'(bus.out_valid), 0);
    chk("idle_or_ir", 32'(bus.in_ready), 1);

    do_op("add9_7", 4'd9, 4'd7, 1'b0, 1'b0, 5'b10000, 1'b0);
    pop("add9_7");
    do_op("add15_0c", 4'd15, 4'd0, 1'b0, 1'b1, 5'b10000, 1'b0);
    pop("add15_0c");
    do_op("sub5_3", 4'd5, 4'd3, 1'b1, 1'b1, 5'b10010, 1'b0);
    pop("sub5_3");
    do_op("sub3_5", 4'd3, 4'd5, 1'b1, 1'b0, 5'b01110, 1'b0);
    pop("sub3_5");
    do_op("add7_1", 4'd7, 4'd1, 1'b0, 1'b0, 5'b01000, 1'b1);
    pop("add7_1");
    do_op("sub8_1", 4'd8, 4'd1, 1'b1, 1'b0, 5'b10111, 1'b1);
    pop("sub8_1");
    do_op("sub6_6", 4'd6, 4'd6, 1'b1, 1'b0, 5'b10000, 1'b0);
    pop("sub6_6");

    // Backpressure: result must hold, new operands ignored
    bus.out_ready = 1'b0;
    do_op("bp", 4'd6, 4'd5, 1'b0, 1'b0, 5'b01011, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bus.A        = 4'(i + 1);
      bus.B        = 4'd3;
      bus.in_valid = i[0];
      @(posedge clk);
      @(negedge clk);
      chk("bp_ov", 32'(bus.out_valid), 1);
      chk("bp_ir", 32'(bus.in_ready), 0);
      chk("bp_S", 32'(bus.S), 32'h0b);
      chk("bp_ovf", 32'(bus.ovf), 1);
    end
    bus.in_valid = 1'b0;
    pop("bp");
    chk("bp_hold_S", 32'(bus.S), 32'h0b);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("bp_noacc", 32'(bus.in_ready), 1);

    // Reset on the 2nd CALC edge discards the operation
    issue(4'd9, 4'd9, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_ir", 32'(bus.in_ready), 1);
    chk("mid_ov", 32'(bus.out_valid), 0);
    chk("mid_S", 32'(bus.S), 0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
        @(posedge clk);
        @(negedge clk);
        if (bus.out_valid) seen = 1;
      end
      chk("mid_noresult", 32'(seen), 0);
    end
    do_op("after_rst", 4'd2, 4'd2, 1'b0, 1'b0, 5'b00100, 1'b0);
    pop("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/somador_serial.md
Name: somador_serial

Overview:
- Bit-serial adder/subtractor: one full-adder cell iterated over N cycles instead of N cascaded cells.
- Parametrised, multi-cycle successor to the 4-bit ripple adder; it trades latency for area.
- Sits between operand producers and result consumers, with a valid/ready handshake on both sides.
- Adds a subtract mode, a carry-in and a signed-overflow flag.

Parameters:
- N, 4, operand width in bits (N >= 2).
- CNT_W, $clog2(N)+1, bit-counter width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
- in_valid  in  1  operands A, B, sub, cin valid.
- in_ready  out  1  block can accept operands.
- A  in  N  operand A, unsigned or two's complement.
- B  in  N  operand B.
- sub  in  1  0 = A+B+cin; 1 = A-B (cin ignored).
- cin  in  1  carry-in for add mode.
- out_valid  out  1  S/ovf hold a completed result.
- out_ready  in  1  consumer accepts result.
- S  out  N+1  result; S[N] = carry-out (in sub mode, 1 = no borrow).
- ovf  out  1  signed overflow of the N-bit result.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, S=0, ovf=0.
  - Internal shift registers, carry and counter are cleared.
  - Reset wins over every other input, including mid-CALC or in DONE; any operation in progress is discarded and no result is produced.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1 at an edge:
    - latch A into shift register RA;
    - latch B, or ~B if sub=1, into RB;
    - carry <= (sub ? 1 : cin); counter <= 0;
    - latch sub for the duration of the operation;
    - go to CALC.
- CALC:
  - in_ready=0.
  - Each edge:
    - sum bit = RA[0]^RB[0]^carry;
    - new carry = majority(RA[0], RB[0], carry);
    - sum bit shifts into the MSB of the result register; RA and RB shift right by one;
    - counter increments.
  - On the edge where the counter reaches N-1 (the Nth CALC edge):
    - result register holds the N sum bits;
    - S[N] <= final carry;
    - ovf <= carry into bit N-1 XOR carry out of bit N-1;
    - go to DONE.
  - in_valid and operand changes during CALC are ignored.
- DONE:
  - out_valid=1 and in_ready=0.
  - S and ovf are stable.
  - On out_ready=1 at an edge: out_valid <= 0, go to IDLE. S and ovf keep their last value until the next result.
  - The next operand is accepted no earlier than the edge after out_valid falls, so there is no back-to-back overlap.
- Latency: operands accepted at edge k; out_valid=1 after edge k+N. Minimum issue interval is N+2 cycles.
- Width/arithmetic:
  - Add: S = A + B + cin, exact to N+1 bits.
  - Sub: S[N-1:0] = (A - B) mod 2^N, S[N] = (A >= B unsigned).
  - ovf uses two's-complement interpretation in both modes.
- Boundary cases:
  - All-ones + 1 wraps S[N-1:0] to 0 with S[N]=1.
  - A==B in sub mode gives S[N-1:0]=0 and S[N]=1.
  - out_ready held high with no result pending has no effect.
  - in_valid with out_valid=1 is not accepted until after the pop.

Test Plan (N=4):
- Reset: rst_n=0 for 2 edges, then 1 → in_ready=1, out_valid=0, S=5'b00000, ovf=0.
- Add with carry-out: A=9, B=7, sub=0, cin=0, out_ready=1 → out_valid rises exactly 4 edges after acceptance; S=5'b10000, ovf=0. A=15, B=0, cin=1 → S=5'b10000.
- Sub: A=5, B=3, sub=1 → S=5'b10010, ovf=0. A=3, B=5 → S=5'b01110 (borrow, S[4]=0), ovf=0.
- Signed overflow: A=7, B=1, add → S=5'b01000, ovf=1. A=8, B=1, sub → S=5'b10111, ovf=1.
- Backpressure: out_ready=0 for 5 cycles after the result → out_valid, S and ovf remain constant and in_ready=0. In-flight in_valid pulses are ignored. out_ready=1 → out_valid falls next edge, in_ready=1.
- Reset mid-operation: pulse rst_n=0 on the 2nd CALC edge → IDLE next edge, out_valid never asserted, S=0. A fresh A=2, B=2 then gives S=5'b00100.
